// File: rtl/irs_event_dma_arbiter_pkg.sv
// Shared types and word formatters for the IRS event-FIFO readout arbiter.
package irs_event_dma_arbiter_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WCNT_W = 12;
    localparam int unsigned IDLE_W = 12;

    localparam logic [3:0] HDR_MARK = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_HDR,
        S_XFER,
        S_TRL,
        S_DONE
    } state_e;

    function automatic logic [DATA_W-1:0] hdr_word(input logic [1:0] addr);
        return {HDR_MARK, 2'b00, addr, 8'h00};
    endfunction

    // Trailer carries the abort flag in the MSB and the saturated word count below.
    function automatic logic [DATA_W-1:0] trl_word(input logic abort, input logic [WCNT_W-1:0] wcnt);
        return {abort, 3'b000, wcnt};
    endfunction

endpackage

// File: rtl/irs_event_dma_arbiter_next_daughter.sv
// Lowest-set-bit finder: picks the next daughter still pending in the event mask.
module irs_event_dma_arbiter_next_daughter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             none_left_o
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx_o       = '0;
        none_left_o = 1'b1;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o       = IDX_W'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/irs_event_dma_arbiter.sv
// Sequences per-event readout of the IRS daughter buffers into the event FIFO,
// framing each daughter's data with a header and a word-count trailer.
module irs_event_dma_arbiter
    import irs_event_dma_arbiter_pkg::*;
#(
    parameter int unsigned NUM_DAUGHTERS = 4,
    parameter int unsigned MAX_DAUGHTERS = 4,
    parameter int unsigned NMXD_BITS     = 2,
    parameter int unsigned SPACE_MARGIN  = 4,
    parameter int unsigned TIMEOUT       = 4095
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     go_i,
    input  logic [MAX_DAUGHTERS-1:0] mask_i,
    input  logic [MAX_DAUGHTERS-1:0] irs_busy_i,
    output logic [NMXD_BITS-1:0]     irs_addr_o,
    input  logic [DATA_W-1:0]        irs_dat_i,
    input  logic                     irs_valid_i,
    input  logic                     irs_empty_i,
    output logic                     irs_read_o,
    input  logic [DATA_W-1:0]        event_space_i,
    output logic [DATA_W-1:0]        event_dat_o,
    output logic                     event_wr_o,
    output logic                     active_o,
    output logic                     done_o,
    output logic [1:0]               err_o
);

    state_e                   state_q, state_d;
    logic [MAX_DAUGHTERS-1:0] mask_q, mask_d, impl_mask;
    logic [NMXD_BITS-1:0]     addr_q, addr_d, nxt_idx;
    logic                     in_flight_q, in_flight_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic [IDLE_W-1:0]        idle_q, idle_d;
    logic                     abort_q, abort_d;
    logic [1:0]               err_q, err_d;
    logic                     active_q, active_d;
    logic                     done_q, done_d;
    logic [DATA_W-1:0]        ev_dat_q, ev_dat_d;
    logic                     ev_wr_q, ev_wr_d;
    logic                     none_left, space_ok, margin_ok, busy_sel;

    irs_event_dma_arbiter_next_daughter #(
        .N     (MAX_DAUGHTERS),
        .IDX_W (NMXD_BITS)
    ) u_next (
        .mask_i      (mask_q),
        .idx_o       (nxt_idx),
        .none_left_o (none_left)
    );

    // Daughters at or above NUM_DAUGHTERS are not populated and never visited.
    always_comb begin
        impl_mask = '0;
        for (int i = 0; i < int'(MAX_DAUGHTERS); i++) begin
            impl_mask[i] = 1'(i < int'(NUM_DAUGHTERS));
        end
    end

    assign space_ok  = (event_space_i != '0);
    assign margin_ok = (event_space_i >= DATA_W'(SPACE_MARGIN));
    assign busy_sel  = irs_busy_i[addr_q];

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        in_flight_d = in_flight_q;
        wcnt_d      = wcnt_q;
        idle_d      = idle_q;
        abort_d     = abort_q;
        err_d       = err_q;
        active_d    = active_q;
        done_d      = 1'b0;
        ev_dat_d    = ev_dat_q;
        ev_wr_d     = 1'b0;
        irs_read_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    mask_d   = mask_i & impl_mask;
                    err_d    = '0;
                    active_d = 1'b1;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (none_left) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    addr_d  = nxt_idx;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (space_ok) begin
                    ev_wr_d     = 1'b1;
                    ev_dat_d    = hdr_word(2'(addr_q));
                    idle_d      = '0;
                    in_flight_d = 1'b0;
                    state_d     = S_XFER;
                end
            end
            S_XFER: begin
                // One read outstanding at a time; the margin guarantees room for its data.
                irs_read_o = !irs_empty_i && margin_ok && !in_flight_q;
                if (irs_valid_i) begin
                    in_flight_d = 1'b0;
                    ev_wr_d     = 1'b1;
                    ev_dat_d    = irs_dat_i;
                    wcnt_d      = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCNT_W'(1);
                    idle_d      = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
                if (irs_read_o) begin
                    in_flight_d = 1'b1;
                end
                if (!busy_sel && irs_empty_i && !in_flight_q) begin
                    state_d = S_TRL;
                end else if (!irs_valid_i && idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    err_d[0]    = 1'b1;
                    abort_d     = 1'b1;
                    in_flight_d = 1'b0;
                    state_d     = S_TRL;
                end
            end
            S_TRL: begin
                if (space_ok) begin
                    ev_wr_d        = 1'b1;
                    ev_dat_d       = trl_word(abort_q, wcnt_q);
                    mask_d[addr_q] = 1'b0;
                    wcnt_d         = '0;
                    abort_d        = 1'b0;
                    state_d        = S_NEXT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_i && state_q != S_IDLE) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            addr_q      <= '0;
            in_flight_q <= 1'b0;
            wcnt_q      <= '0;
            idle_q      <= '0;
            abort_q     <= 1'b0;
            err_q       <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            ev_dat_q    <= '0;
            ev_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            in_flight_q <= in_flight_d;
            wcnt_q      <= wcnt_d;
            idle_q      <= idle_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            active_q    <= active_d;
            done_q      <= done_d;
            ev_dat_q    <= ev_dat_d;
            ev_wr_q     <= ev_wr_d;
        end
    end

    assign irs_addr_o  = addr_q;
    assign event_dat_o = ev_dat_q;
    assign event_wr_o  = ev_wr_q;
    assign active_o    = active_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
